// File: rtl/aes_iter_engine_if.sv
// Block handshake bundle for aes_iter_engine.
// master = block source/sink side, slave = engine side.
interface aes_iter_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plain_text;
  logic [127:0] cipher_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] cipher_text;
  logic         busy;

  modport master (
    output in_valid,
    output plain_text,
    output cipher_key,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  cipher_text,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  plain_text,
    input  cipher_key,
    input  out_ready,
    output in_ready,
    output out_valid,
    output cipher_text,
    output busy
  );
endinterface

// File: rtl/aes_iter_engine.sv
// Self-sequencing AES-128 encryption engine, ROUNDS_PER_CYCLE rounds per clock.
// Optional block counter enabled by defining AES_BLKCNT_EN.
package aes_iter_engine_pkg;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so the slice base is 8*(255-b).
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

module subBytes_top
  import aes_iter_engine_pkg::*;
(
  input  logic [127:0] data,
  output logic [127:0] result
);
  always_comb begin
    result = '0;
    for (int i = 0; i < 16; i++)
      result[8*i +: 8] = sbox(data[8*i +: 8]);
  end
endmodule

module shiftRows_top (
  input  logic [127:0] data,
  output logic [127:0] result
);
  // Byte j is row j%4, column j/4; row r rotates left by r.
  always_comb begin
    result = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        result[127-8*(r+4*c) -: 8] =
          data[127-8*(r+4*((c+r)%4)) -: 8];
  end
endmodule

module MixCol_top
  import aes_iter_engine_pkg::*;
(
  input  logic [127:0] data,
  output logic [127:0] result
);
  function automatic logic [31:0] mix(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    return {
      xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
    };
  endfunction

  always_comb begin
    result = '0;
    for (int c = 0; c < 4; c++)
      result[127-32*c -: 32] = mix(data[127-32*c -: 32]);
  end
endmodule

module AddRndKey_top (
  input  logic [127:0] data,
  input  logic [127:0] key,
  output logic [127:0] result
);
  assign result = data ^ key;
endmodule

module KeySchedule_top
  import aes_iter_engine_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   rnd,
  output logic [127:0] result
);
  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t, n0, n1, n2, n3;

  always_comb begin
    rcon = 8'h00;
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign {w0, w1, w2, w3} = key;

  assign t = {sbox(w3[23:16]), sbox(w3[15:8]),
              sbox(w3[7:0]), sbox(w3[31:24])}
           ^ {rcon, 24'h0};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign result = {n0, n1, n2, n3};
endmodule

module aes_iter_engine #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
`ifdef AES_BLKCNT_EN
  input  logic        blk_count_clr,
  output logic [31:0] blk_count,
`endif
  aes_iter_engine_if.slave bus
);
  localparam int NUM_ROUNDS = 10;

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10))
  begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t          st;
  logic [127:0] blk;
  logic [127:0] rk;
  logic [3:0]   rnd;
  logic [127:0] ct;
  logic         ov;
  logic         accept;
  logic         last;

  logic [127:0] s_chain [0:ROUNDS_PER_CYCLE];
  logic [127:0] k_chain [0:ROUNDS_PER_CYCLE];

  assign s_chain[0] = blk;
  assign k_chain[0] = rk;

  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_rnd
    logic [3:0]   num;
    logic [127:0] sb, sr, mc, mix_sel;

    assign num = rnd + 4'(i);

    subBytes_top u_sb (.data(s_chain[i]), .result(sb));
    shiftRows_top u_sr (.data(sb), .result(sr));
    MixCol_top u_mc (.data(sr), .result(mc));

    KeySchedule_top u_ks (
      .key(k_chain[i]),
      .rnd(num),
      .result(k_chain[i+1])
    );

    // The final round skips MixColumns.
    assign mix_sel = (num == 4'(NUM_ROUNDS)) ? sr : mc;

    AddRndKey_top u_ark (
      .data(mix_sel),
      .key(k_chain[i+1]),
      .result(s_chain[i+1])
    );
  end

  assign last = (rnd == 4'(NUM_ROUNDS + 1 - ROUNDS_PER_CYCLE));

  assign bus.in_ready    = (st == IDLE) ||
                           (st == DONE && bus.out_ready);
  assign bus.out_valid   = ov;
  assign bus.cipher_text = ct;
  assign bus.busy        = (st == RUN);

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= IDLE;
      blk <= '0;
      rk  <= '0;
      rnd <= '0;
      ct  <= '0;
      ov  <= 1'b0;
    end else begin
      unique case (st)
        IDLE: ;
        RUN: begin
          blk <= s_chain[ROUNDS_PER_CYCLE];
          rk  <= k_chain[ROUNDS_PER_CYCLE];
          rnd <= rnd + 4'(ROUNDS_PER_CYCLE);
          if (last) begin
            ct <= s_chain[ROUNDS_PER_CYCLE];
            ov <= 1'b1;
            st <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov <= 1'b0;
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
      // A new block may be taken on the same edge as the drain.
      if (accept) begin
        blk <= bus.plain_text ^ bus.cipher_key;
        rk  <= bus.cipher_key;
        rnd <= 4'd1;
        st  <= RUN;
      end
    end
  end

`ifdef AES_BLKCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      blk_count <= '0;
    else if (blk_count_clr)
      blk_count <= '0;
    else if (bus.out_valid && bus.out_ready)
      blk_count <= blk_count + 32'd1;
  end
`endif
endmodule

// File: doc/aes_iter_engine.md
Name: aes_iter_engine

Overview:
Self-sequencing AES-128 encryption engine with an internal round FSM, replacing the external controller plus datapath split. It instantiates ROUNDS_PER_CYCLE copies of the round datapath: subBytes_top, shiftRows_top, MixCol_top, AddRndKey_top and KeySchedule_top. This trades area against latency. Blocks are accepted and returned through valid/ready handshakes, so the engine sits directly between a block source and sink with no testbench sequencing.

Parameters:
ROUNDS_PER_CYCLE, 1, AES rounds unrolled per clock; legal values 1, 2, 5, 10; any other value must fail elaboration.
NUM_ROUNDS, 10, fixed AES-128 round count; local, not overridable.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  plain_text/cipher_key are valid
in_ready  output  1  engine can accept a block this cycle
plain_text  input  128  plaintext block, FIPS-197 byte order (byte 0 = MSB)
cipher_key  input  128  AES-128 key, same byte order
out_valid  output  1  cipher_text is valid
out_ready  input  1  sink accepts cipher_text this cycle
cipher_text  output  128  ciphertext block
busy  output  1  high in RUN state

Behaviour:
- Reset (async assert, synchronous-to-clk deassert handled externally): state=IDLE, out_valid=0, cipher_text=0, internal state/round-key/round counter=0. in_ready=1 after reset, busy=0.
- States: IDLE, RUN, DONE.
- Accept: in_valid && in_ready.
  - Latches state <= plain_text ^ cipher_key (initial AddRoundKey).
  - Latches rk <= cipher_key and rnd <= 1.
  - Goes to RUN.
- RUN, per cycle: applies rounds rnd .. rnd+ROUNDS_PER_CYCLE-1 combinationally.
  - Each round: SubBytes, ShiftRows, MixColumns, AddRoundKey, with the key expanded via KeySchedule_top using that round's number for Rcon.
  - MixColumns is bypassed only for round 10.
  - Registers the resulting state and key, then rnd <= rnd+ROUNDS_PER_CYCLE.
- RUN exit: when the registered rounds include round 10, cipher_text <= final state, out_valid <= 1, and the FSM goes to DONE.
- Latency, accept edge to out_valid high: 10/ROUNDS_PER_CYCLE cycles.
  - 10, 5, 2, 1 cycles for R=1, 2, 5, 10.
- DONE:
  - cipher_text is held stable and out_valid stays 1 until out_ready.
  - out_ready=1 with no new accept: out_valid <= 0, go to IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives a back-to-back accept on the same edge as the drain.
  - Simultaneous drain and accept goes straight to RUN.
  - out_valid drops the next cycle.
- in_valid during RUN is ignored (in_ready=0); inputs need not be held after the accept edge.
- plain_text/cipher_key changes after accept have no effect on the block in flight.
- rst asserted mid-RUN or in DONE: the in-flight block is discarded, outputs go to reset values immediately (async), and no partial ciphertext is ever presented.
- out_valid never asserts without a preceding accept. Exactly one output per accepted block.

Optional Feature:
Macro AES_BLKCNT_EN.
- Defined:
  - Adds output blk_count [31:0], reset to 0.
  - Increments on every out_valid && out_ready handshake and wraps 0xFFFFFFFF -> 0.
  - Adds input blk_count_clr, a synchronous clear that takes priority over the increment in the same cycle.
- Undefined: neither port exists, and no counter logic is generated.

Test Plan:
- R=1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1 -> out_valid rises 10 cycles after accept, ct 69c4e0d86a7b0430d8cdb78070b4c55a, in_ready=0 during RUN.
- R=2 and R=5 (separate builds), key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32 after 5 and 2 cycles respectively.
- Backpressure: hold out_ready=0 for 7 cycles after out_valid, toggle in_valid and the inputs -> cipher_text stable, no new accept. Then out_ready=1 with in_valid=1 -> drain and accept on the same edge, second block correct.
- Reset mid-operation: assert rst at round 4 -> out_valid=0, cipher_text=0, in_ready=1 immediately after release; a new block then completes with the correct ct.
- Streaming: 100 random key/pt pairs with a reference model, random out_ready -> all ct match in order, count equals 100.
- AES_BLKCNT_EN: after 3 drained blocks blk_count=3. Assert blk_count_clr on the same cycle as the 4th drain -> blk_count=0. Preload near wrap via forced value 0xFFFFFFFF, drain once -> 0.
